// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state
// encoding and the ALU operation codes used by the block and its bench.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ALU operation codes, passed through to the shared ALU untouched.
  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_SLL = 5'b00010;
  localparam logic [4:0] OP_SRL = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_BEQ = 5'b01101;

  // Requester index carried by a one-hot two-way grant.
  function automatic logic grant_to_id(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way arbiter producing a one-hot grant.
// Default build: round-robin with a last-grant pointer that moves only when
// a grant is issued while enabled; after reset requester 0 wins a tie.
// With ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 wins ties,
// and no pointer state exists.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       en,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Clock and reset are not needed without pointer state.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Fixed priority: requester 0 first.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid0)      grant = 2'b01;
      else if (valid1) grant = 2'b10;
    end
  end

`else

  // 1 = requester 1 was granted most recently.
  logic last_reg;

  // Round-robin: on a tie grant the requester that did not win last time.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid0 && valid1) grant = last_reg ? 2'b01 : 2'b10;
      else if (valid0)      grant = 2'b01;
      else if (valid1)      grant = 2'b10;
    end
  end

  // Pointer follows each issued grant; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (en && (grant != 2'b00)) begin
      last_reg <= grant[1];
    end
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
// IDLE accepts one request (combinational ready), EXEC drives the ALU and
// captures its result, RESP holds the response until it is taken.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed-priority
// arbitration instead of round-robin.
// DATA_W is only supported at 32.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [4:0]        req0_shamt,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [4:0]        req1_shamt,
  output logic              req1_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_data_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_id
);

  state_t state_reg, state_next;

  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [4:0]        shamt_reg;
  logic              id_reg;
  logic [DATA_W-1:0] data_reg;
  logic              zero_reg;

  logic              arb_en;
  logic [1:0]        grant;
  logic [1:0]        ready_vec;
  logic              accept;
  logic              sel_id;

  // Ready is withheld while reset is asserted even though the state is IDLE.
  assign arb_en = (state_reg == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .en     (arb_en),
    .grant  (grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = arb_en & grant[gi];
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;
  assign sel_id     = grant_to_id(grant);

  // Next-state and ALU/response outputs; ALU bus is zero outside EXEC.
  always_comb begin
    state_next = state_reg;
    alu_op     = '0;
    alu_in1    = '0;
    alu_in2    = '0;
    alu_shamt  = '0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        alu_op     = op_reg;
        alu_in1    = a_reg;
        alu_in2    = b_reg;
        alu_shamt  = shamt_reg;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Latch the granted requester's operation on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      shamt_reg <= '0;
      id_reg    <= 1'b0;
    end else if (accept) begin
      op_reg    <= sel_id ? req1_op    : req0_op;
      a_reg     <= sel_id ? req1_a     : req0_a;
      b_reg     <= sel_id ? req1_b     : req0_b;
      shamt_reg <= sel_id ? req1_shamt : req0_shamt;
      id_reg    <= sel_id;
    end
  end

  // Capture the ALU result at the end of EXEC; held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      zero_reg <= 1'b0;
    end else if (state_reg == EXEC) begin
      data_reg <= alu_data_out;
      zero_reg <= alu_zero;
    end
  end

  assign rsp_data = data_reg;
  assign rsp_zero = zero_reg;
  assign rsp_id   = id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small external ALU model.
// Honours ALU_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        req0_ready, req1_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_data_out;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [10];

  alu_arbiter #(.DATA_W(32), .OP_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a),
    .req0_b(req0_b), .req0_shamt(req0_shamt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a),
    .req1_b(req1_b), .req1_shamt(req1_shamt), .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_shamt(alu_shamt), .alu_data_out(alu_data_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_id(rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: shifts act on in2; undefined codes return zero.
  always_comb begin
    alu_data_out = 32'h0;
    case (alu_op)
      OP_AND:  alu_data_out = alu_in1 & alu_in2;
      OP_OR:   alu_data_out = alu_in1 | alu_in2;
      OP_SLL:  alu_data_out = alu_in2 << alu_shamt;
      OP_SRL:  alu_data_out = alu_in2 >> alu_shamt;
      OP_ADD:  alu_data_out = alu_in1 + alu_in2;
      OP_SUB:  alu_data_out = alu_in1 - alu_in2;
      OP_BEQ:  alu_data_out = alu_in1 - alu_in2;
      default: alu_data_out = 32'h0;
    endcase
    alu_zero = (alu_data_out == 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] shamt);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = shamt;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = shamt;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Wait (bounded) for a ready; reports which requester was granted.
  task automatic wait_grant(output logic gid, output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    gid = 1'b0;
    while (n < 8) begin
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        gid = req1_ready;
        break;
      end
      tick();
      n++;
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    else     chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
  endtask

  // One request from one requester, rsp_ready high, exact latency checked.
  task automatic run_single(input vec_t v, input int idx);
    logic gid, ok;
    drive_req(v.id, v.op, v.a, v.b, v.shamt);
    #1;
    wait_grant(gid, ok);
    if (!ok) begin
      clear_reqs();
      return;
    end
    chk("grant_id", {31'd0, gid}, {31'd0, v.id});
    tick();
    clear_reqs();
    #1;
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("alu_op", {27'd0, alu_op}, {27'd0, v.op});
    chk("alu_in1", alu_in1, v.a);
    chk("alu_in2", alu_in2, v.b);
    tick();
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.exp_zero});
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, v.id});
    chk("resp_alu_zeroed", alu_in1, 32'd0);
    $display("txn %0d: id=%0d op=%b a=%h b=%h data=%h zero=%0d", idx, v.id, v.op,
             v.a, v.b, rsp_data, rsp_zero);
    tick();
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gid, ok, exp_id;

    vecs[0] = '{1'b0, OP_ADD, 32'd5,          32'd7,          5'd0,  32'd12,         1'b0};
    vecs[1] = '{1'b1, OP_SUB, 32'd10,         32'd3,          5'd0,  32'd7,          1'b0};
    vecs[2] = '{1'b0, OP_SUB, 32'd3,          32'd3,          5'd0,  32'd0,          1'b1};
    vecs[3] = '{1'b1, OP_AND, 32'hff00ff00,   32'h0ff00ff0,   5'd0,  32'h0f000f00,   1'b0};
    vecs[4] = '{1'b0, OP_OR,  32'h000000f0,   32'h0000000f,   5'd0,  32'h000000ff,   1'b0};
    vecs[5] = '{1'b1, OP_SLL, 32'd0,          32'd1,          5'd31, 32'h80000000,   1'b0};
    vecs[6] = '{1'b0, OP_SRL, 32'd0,          32'h80000000,   5'd31, 32'd1,          1'b0};
    vecs[7] = '{1'b1, 5'b11111, 32'd9,        32'd9,          5'd3,  32'd0,          1'b1};
    vecs[8] = '{1'b0, OP_ADD, 32'hffffffff,   32'd1,          5'd0,  32'd0,          1'b1};
    vecs[9] = '{1'b1, OP_BEQ, 32'd1,          32'd2,          5'd0,  32'hffffffff,   1'b0};

    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_op = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
    req1_op = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    #2;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_reqs();
    tick();

    // Table of single-requester operations.
    for (int i = 0; i < 10; i++) run_single(vecs[i], i);

    // Both requesting continuously: grants alternate (fixed build: always 0).
    drive_req(1'b0, OP_SUB, 32'd3, 32'd3, 5'd0);
    drive_req(1'b1, OP_SUB, 32'd3, 32'd3, 5'd0);
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = k[0];
`endif
      wait_grant(gid, ok);
      if (!ok) break;
      chk("tie_grant", {31'd0, gid}, {31'd0, exp_id});
      tick();
      chk("tie_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
      chk("tie_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("tie_rsp_data", rsp_data, 32'd0);
      chk("tie_rsp_zero", {31'd0, rsp_zero}, 32'd1);
      chk("tie_rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
      $display("tie txn %0d: granted=%0d rsp_id=%0d data=%h", k, gid, rsp_id, rsp_data);
      tick();
    end
    clear_reqs();
    tick();

    // Backpressure in RESP, plus a short-lived req1 that must be dropped.
    rsp_ready = 1'b0;
    drive_req(1'b0, OP_SLL, 32'd0, 32'd1, 5'd4);
    #1;
    wait_grant(gid, ok);
    chk("bp_grant", {31'd0, gid}, 32'd0);
    tick();
    clear_reqs();
    #1;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) drive_req(1'b1, OP_ADD, 32'd1, 32'd1, 5'd0);
      if (c == 2) req1_valid = 1'b0;
      #1;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", rsp_data, 32'd16);
      chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rsp_valid_hs", {31'd0, rsp_valid}, 32'd1);
    chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
    $display("bp txn: data=%h held 5 cycles", rsp_data);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("drop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("drop_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end

    // Reset during EXEC discards req1's BEQ; next tie goes to requester 0.
    drive_req(1'b1, OP_BEQ, 32'd1, 32'd1, 5'd0);
    #1;
    wait_grant(gid, ok);
    chk("rst_txn_grant", {31'd0, gid}, 32'd1);
    tick();
    clear_reqs();
    #1;
    chk("rst_txn_exec_op", {27'd0, alu_op}, {27'd0, OP_BEQ});
    rst = 1'b1;
    #1;
    chk("rst_txn_alu_cleared", {27'd0, alu_op}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("rst_txn_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    drive_req(1'b0, OP_ADD, 32'd2, 32'd3, 5'd0);
    drive_req(1'b1, OP_ADD, 32'd2, 32'd3, 5'd0);
    #1;
    wait_grant(gid, ok);
    chk("post_rst_tie", {31'd0, gid}, 32'd0);
    tick();
    clear_reqs();
    #1;
    tick();
    chk("post_rst_rsp_data", rsp_data, 32'd5);
    chk("post_rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    $display("post-reset txn: granted=%0d data=%h", gid, rsp_data);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
